// File: rtl/alu_reservation_station_if.sv
// rtl/alu_reservation_station_if.sv - issue, CDB, ALU-offer and status bundle for the ALU reservation station
interface alu_reservation_station_if #(
  parameter int TAG_W = 4
) ();
  logic             issue_valid;
  logic [1:0]       issue_op;
  logic [31:0]      issue_vj;
  logic [31:0]      issue_vk;
  logic [TAG_W-1:0] issue_qj;
  logic [TAG_W-1:0] issue_qk;
  logic             issue_ready;
  logic [TAG_W-1:0] issue_tag;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             alu_available;
  logic             alu_wen;
  logic [1:0]       alu_op;
  logic [31:0]      alu_data1;
  logic [31:0]      alu_data2;
  logic [TAG_W-1:0] alu_tag;
  logic [2:0]       busy_count;

  // Issue unit, CDB and ALU side (drives the station's inputs)
  modport master (
    output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    output cdb_valid, cdb_tag, cdb_data, alu_available,
    input  issue_ready, issue_tag, alu_wen, alu_op, alu_data1, alu_data2, alu_tag, busy_count
  );

  // Reservation station side
  modport slave (
    input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
    input  cdb_valid, cdb_tag, cdb_data, alu_available,
    output issue_ready, issue_tag, alu_wen, alu_op, alu_data1, alu_data2, alu_tag, busy_count
  );
endinterface

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - ALU reservation station with CDB snooping; optional oldest-first select via RS_AGE_SELECT_EN
module alu_reservation_station #(
  parameter int ENTRIES = 3,
  parameter int TAG_W   = 4,
  parameter int RS_BASE = 1
) (
  input logic                      clk,
  input logic                      nRST,
  alu_reservation_station_if.slave rs
);

  // Entry i answers to tag RS_BASE+i on the CDB
  function automatic logic [TAG_W-1:0] own_tag(input int idx);
    return TAG_W'(RS_BASE + idx);
  endfunction

  logic [ENTRIES-1:0] busy_q, busy_d;
  logic [ENTRIES-1:0] disp_q, disp_d;
  logic [1:0]         op_q [ENTRIES];
  logic [1:0]         op_d [ENTRIES];
  logic [31:0]        vj_q [ENTRIES];
  logic [31:0]        vj_d [ENTRIES];
  logic [31:0]        vk_q [ENTRIES];
  logic [31:0]        vk_d [ENTRIES];
  logic [TAG_W-1:0]   qj_q [ENTRIES];
  logic [TAG_W-1:0]   qj_d [ENTRIES];
  logic [TAG_W-1:0]   qk_q [ENTRIES];
  logic [TAG_W-1:0]   qk_d [ENTRIES];
  logic [2:0]         busy_count_q, busy_count_d;

  logic               free_found;
  logic [2:0]         free_idx;
  logic [ENTRIES-1:0] ready;
  logic               sel_found;
  logic [2:0]         sel_idx;
  logic               issue_fire;
  logic               dispatch_fire;

  logic [1:0]         alu_op_o;
  logic [31:0]        alu_data1_o;
  logic [31:0]        alu_data2_o;
  logic [TAG_W-1:0]   alu_tag_o;

  // Lowest non-busy entry receives the next issued instruction
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  // An entry may be offered once both operands are present and it has not gone to the ALU yet
  always_comb begin
    ready = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      ready[i] = busy_q[i] && !disp_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

`ifdef RS_AGE_SELECT_EN
  localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [AW-1:0] age_q [ENTRIES];
  logic [AW-1:0] age_d [ENTRIES];
  logic [AW-1:0] best_age;

  // Oldest ready entry wins; the strict compare leaves ties on the lower index
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    best_age  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ready[i] && (!sel_found || (age_q[i] > best_age))) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
        best_age  = age_q[i];
      end
    end
  end

  // Ages count later issues: the newcomer starts at 0, every other busy entry ages by one
  always_comb begin
    age_d = age_q;
    if (issue_fire) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (free_idx == 3'(i)) begin
          age_d[i] = '0;
        end else if (busy_q[i] && (age_q[i] != '1)) begin
          age_d[i] = age_q[i] + 1'b1;
        end
      end
    end
  end

  // Age registers
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= '0;
    end else begin
      age_q <= age_d;
    end
  end
`else
  // Lowest-index ready entry wins
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = 3'(i);
      end
    end
  end
`endif

  assign issue_fire    = rs.issue_valid && free_found;
  assign dispatch_fire = sel_found && rs.alu_available;

  // Per-entry next state: allocate free slots, wake operands, mark dispatch, free on own tag
  always_comb begin
    busy_d = busy_q;
    disp_d = disp_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i]) begin
        if (rs.cdb_valid && (qj_q[i] != '0) && (qj_q[i] == rs.cdb_tag)) begin
          vj_d[i] = rs.cdb_data;
          qj_d[i] = '0;
        end
        if (rs.cdb_valid && (qk_q[i] != '0) && (qk_q[i] == rs.cdb_tag)) begin
          vk_d[i] = rs.cdb_data;
          qk_d[i] = '0;
        end
        if (dispatch_fire && (sel_idx == 3'(i))) begin
          disp_d[i] = 1'b1;
        end
        // The result of this entry is on the CDB, so its tag is no longer in flight
        if (rs.cdb_valid && (rs.cdb_tag == own_tag(i))) begin
          busy_d[i] = 1'b0;
          disp_d[i] = 1'b0;
        end
      end else if (issue_fire && (free_idx == 3'(i))) begin
        busy_d[i] = 1'b1;
        disp_d[i] = 1'b0;
        op_d[i]   = rs.issue_op;
        // Capture an operand that is being broadcast in the same cycle it is issued
        if (rs.cdb_valid && (rs.issue_qj != '0) && (rs.issue_qj == rs.cdb_tag)) begin
          vj_d[i] = rs.cdb_data;
          qj_d[i] = '0;
        end else begin
          vj_d[i] = rs.issue_vj;
          qj_d[i] = rs.issue_qj;
        end
        if (rs.cdb_valid && (rs.issue_qk != '0) && (rs.issue_qk == rs.cdb_tag)) begin
          vk_d[i] = rs.cdb_data;
          qk_d[i] = '0;
        end else begin
          vk_d[i] = rs.issue_vk;
          qk_d[i] = rs.issue_qk;
        end
      end
    end
    busy_count_d = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      busy_count_d = busy_count_d + 3'(busy_d[i]);
    end
  end

  // Entry state registers; reset drops every entry immediately
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      busy_q       <= '0;
      disp_q       <= '0;
      busy_count_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else begin
      busy_q       <= busy_d;
      disp_q       <= disp_d;
      busy_count_q <= busy_count_d;
      op_q         <= op_d;
      vj_q         <= vj_d;
      vk_q         <= vk_d;
      qj_q         <= qj_d;
      qk_q         <= qk_d;
    end
  end

  // Present the selected entry to the ALU; everything reads zero when nothing is offered
  always_comb begin
    alu_op_o    = '0;
    alu_data1_o = '0;
    alu_data2_o = '0;
    alu_tag_o   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel_found && (sel_idx == 3'(i))) begin
        alu_op_o    = op_q[i];
        alu_data1_o = vj_q[i];
        alu_data2_o = vk_q[i];
        alu_tag_o   = own_tag(i);
      end
    end
  end

  assign rs.issue_ready = free_found;
  assign rs.issue_tag   = own_tag(int'(free_idx));
  assign rs.alu_wen     = sel_found;
  assign rs.alu_op      = alu_op_o;
  assign rs.alu_data1   = alu_data1_o;
  assign rs.alu_data2   = alu_data2_o;
  assign rs.alu_tag     = alu_tag_o;
  assign rs.busy_count  = busy_count_q;

endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
Reservation station that sits directly upstream of the add/sub ALU stage (State + pmfALU pair). It holds issued ALU instructions and snoops the common data bus (CDB) for pending operands. It dispatches one ready instruction per cycle to the ALU using the ALU's available/WEN handshake. An entry is freed only when its own result tag is broadcast on the CDB, so each tag stays unique while it is in flight.

Parameters:
ENTRIES, 3, number of station entries (1..7)
TAG_W, 4, width of producer tags; tag value 0 means "operand valid, no dependency"
RS_BASE, 1, tag of entry 0; entry i owns tag RS_BASE+i; RS_BASE+ENTRIES-1 must be < 2^TAG_W and RS_BASE must be ≠0

Ports:
clk  in  1  clock
nRST  in  1  reset; asynchronous, active-low
issue_valid  in  1  issue unit presents an instruction
issue_op  in  2  ALU op code (ALUAdd/ALUSub encodings from head.v)
issue_vj  in  32  operand 1 value, meaningful when issue_qj==0
issue_vk  in  32  operand 2 value, meaningful when issue_qk==0
issue_qj  in  TAG_W  producer tag of operand 1 (0 = ready)
issue_qk  in  TAG_W  producer tag of operand 2 (0 = ready)
issue_ready  out  1  at least one free entry; issue accepted only when issue_valid && issue_ready
issue_tag  out  TAG_W  tag that the instruction accepted this cycle receives
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast producer tag
cdb_data  in  32  broadcast result
alu_available  in  1  ALU State.available
alu_wen  out  1  a ready entry is being offered (drives ALU WEN)
alu_op  out  2  op of offered entry
alu_data1  out  32  Vj of offered entry
alu_data2  out  32  Vk of offered entry
alu_tag  out  TAG_W  tag of offered entry (travels with result to CDB)
busy_count  out  3  number of busy entries

Behaviour:
- Per-entry state: busy, dispatched, op, Vj, Vk, Qj, Qk. nRST low clears busy/dispatched/Q* and zeroes V*. This applies at any time, including mid-operation: all entries are dropped.
- Reset output values: issue_ready=1, issue_tag=RS_BASE, alu_wen=0, alu_op=0, alu_data1=0, alu_data2=0, alu_tag=0, busy_count=0.
- Allocation: issue_tag = RS_BASE + index of the lowest non-busy entry. issue_ready = any entry non-busy. Both are derived only from registered state.
- Issue with issue_valid && !issue_ready: ignored, no state change.
- Accepted issue sets busy=1 and dispatched=0 at the clock edge.
- Issue-time bypass: if cdb_valid and issue_qj==cdb_tag (nonzero), store Vj=cdb_data, Qj=0. Same rule for k.
- Wakeup: for every busy entry with Qj==cdb_tag && cdb_valid && Qj≠0, set Vj=cdb_data, Qj=0. Same rule for k. Both operands may wake in the same cycle.
- Ready: busy && !dispatched && Qj==0 && Qk==0, evaluated on registered state. An entry woken at edge N is eligible from cycle N+1.
- Select: lowest-index ready entry (default).
- alu_wen=1 when any entry is ready. alu_op/data/tag are combinational from the selected entry and are 0 when alu_wen=0.
- Dispatch handshake: alu_wen && alu_available at the edge sets dispatched=1 on the selected entry. Operands are held stable until that edge, so the ALU latches them then.
- Free: cdb_valid && cdb_tag == own tag with busy=1 clears busy and dispatched.
- Free/issue interaction: an entry freed at edge N is not reallocated in the same cycle; it shows in issue_ready/issue_tag from cycle N+1.
- CDB tag matching no busy entry: wakeup-only; no entry is freed.
- busy_count: registered popcount of busy.

Optional Feature:
RS_AGE_SELECT_EN: when defined, each entry carries an age counter of width clog2(ENTRIES).
- Issue sets age=0; every other busy entry increments, saturating.
- Select picks the oldest ready entry; ties go to the lower index.
- Undefined: lowest-index select only; no age registers are instantiated.

Test Plan:
1. Reset: hold nRST low, then release. Require issue_ready=1, issue_tag=1, alu_wen=0, busy_count=0.
2. Issue add with Vj=5, Vk=7, Qj=Qk=0, and alu_available=1. Require alu_wen=1 next cycle with alu_data1=5, alu_data2=7, alu_tag=1. Require alu_wen=0 after the dispatch edge. Then CDB tag=1 -> busy_count=0.
3. Issue sub with Qj=3, Vk=2. Hold alu_wen=0. CDB tag=3, data=10 -> one cycle later alu_wen=1, alu_data1=10, alu_data2=2.
4. Issue with issue_qk=2 while cdb_valid, cdb_tag=2, cdb_data=9 in the same cycle (bypass) -> entry ready next cycle with alu_data2=9.
5. Fill 3 entries -> issue_ready=0, and a 4th issue is ignored. CDB tag=2 -> next cycle issue_ready=1, issue_tag=2. Not in the same cycle as the broadcast.
6. Two ready entries (tags 1, 2) with alu_available=0 for 3 cycles -> tag 1 offered steadily. Then available=1 -> tag 1 dispatched, tag 2 offered next cycle. With RS_AGE_SELECT_EN and tag 2 issued first, require tag 2 to be offered first.
